// File: rtl/vga_pixer.sv
// vga_pixer: watches a 6-bit VGA stream, measures line/frame geometry, emits active-window pixels.
// Define PIXER_CRC_EN to build a per-frame CRC-16-CCITT over the captured pixels.
module vga_pixer #(
  parameter bit SYNC_POL = 1'b0,
  parameter int HCNT_W   = 12,
  parameter int VCNT_W   = 11,
  parameter int H_START  = 128,
  parameter int H_ACTIVE = 640,
  parameter int V_START  = 40,
  parameter int V_ACTIVE = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [1:0]        red,
  input  logic [1:0]        grn,
  input  logic [1:0]        blu,
  output logic              pix_valid,
  output logic [HCNT_W-1:0] pix_x,
  output logic [VCNT_W-1:0] pix_y,
  output logic [5:0]        pix_rgb,
  output logic [HCNT_W-1:0] line_len,
  output logic [VCNT_W-1:0] frame_lines,
  output logic [15:0]       frame_cnt,
  output logic              frame_done,
  output logic [15:0]       frame_crc
);
  logic hs1, vs1, hs2, vs2, h_seen, v_seen, hs_edge, vs_edge, valid_n;
  logic [5:0] rgb1;
  logic [HCNT_W-1:0] hcnt, h_inc, h_idx;
  logic [VCNT_W-1:0] vcnt, v_inc, v_idx;
  // hcnt/vcnt hold the index of the previous s1 pixel; h_idx/v_idx index the pixel now in s1
  always_comb begin
    hs_edge = hs1 == SYNC_POL && hs2 != SYNC_POL;
    vs_edge = vs1 == SYNC_POL && vs2 != SYNC_POL;
    h_inc = &hcnt ? hcnt : hcnt + HCNT_W'(1);
    v_inc = &vcnt ? vcnt : vcnt + VCNT_W'(1);
    h_idx = hs_edge ? '0 : h_inc;
    v_idx = vs_edge ? '0 : hs_edge ? v_inc : vcnt;
    valid_n = 32'(h_idx) >= H_START && 32'(h_idx) < H_START + H_ACTIVE &&
              32'(v_idx) >= V_START && 32'(v_idx) < V_START + V_ACTIVE &&
              hs1 != SYNC_POL && vs1 != SYNC_POL && v_seen;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1 <= !SYNC_POL;
      vs1 <= !SYNC_POL;
      hs2 <= !SYNC_POL;
      vs2 <= !SYNC_POL;
      rgb1 <= '0;
      hcnt <= '0;
      vcnt <= '0;
      h_seen <= 1'b0;
      v_seen <= 1'b0;
      line_len <= '0;
      frame_lines <= '0;
      frame_cnt <= '0;
      frame_done <= 1'b0;
      pix_valid <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      pix_rgb <= '0;
    end else begin
      hs1 <= hsync;
      vs1 <= vsync;
      rgb1 <= {red, grn, blu};
      hs2 <= hs1;
      vs2 <= vs1;
      hcnt <= h_idx;
      vcnt <= v_idx;
      h_seen <= h_seen | hs_edge;
      v_seen <= v_seen | vs_edge;
      if (hs_edge && h_seen) line_len <= h_inc;
      if (vs_edge && v_seen) frame_lines <= v_inc;
      if (vs_edge) frame_cnt <= frame_cnt + 16'd1;
      frame_done <= vs_edge;
      pix_valid <= valid_n;
      if (valid_n) begin
        pix_x <= h_idx - HCNT_W'(H_START);
        pix_y <= v_idx - VCNT_W'(V_START);
        pix_rgb <= rgb1;
      end
    end
  end
`ifdef PIXER_CRC_EN
  logic [15:0] crc_acc;
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? (r << 1) ^ 16'h1021 : r << 1;
    return r;
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_acc <= 16'hFFFF;
      frame_crc <= '0;
    end else if (vs_edge) begin
      frame_crc <= crc_acc;
      crc_acc <= 16'hFFFF;
    end else if (valid_n) begin
      crc_acc <= crc_byte(crc_acc, {2'b00, rgb1});
    end
  end
`else
  assign frame_crc = '0;
`endif
endmodule

// File: tb/tb_vga_pixer.sv
// tb_vga_pixer: randomized VGA stream against a clock-by-clock reference of the capture rules.
module tb_vga_pixer;
  localparam int HW = 8, VW = 6, HST = 8, HACT = 16, VST = 3, VACT = 5;
  localparam int HMAX = 255, VMAX = 63;
  localparam bit POL = 1'b0;
  logic clk = 0, rst_n = 0, hsync = 1, vsync = 1;
  logic [1:0] red = 0, grn = 0, blu = 0;
  logic pix_valid, frame_done;
  logic [HW-1:0] pix_x, line_len;
  logic [VW-1:0] pix_y, frame_lines;
  logic [5:0] pix_rgb;
  logic [15:0] frame_cnt, frame_crc;
  vga_pixer #(.SYNC_POL(POL), .HCNT_W(HW), .VCNT_W(VW), .H_START(HST), .H_ACTIVE(HACT),
              .V_START(VST), .V_ACTIVE(VACT)) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .red(red), .grn(grn), .blu(blu),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .line_len(line_len), .frame_lines(frame_lines), .frame_cnt(frame_cnt),
    .frame_done(frame_done), .frame_crc(frame_crc));
  always #5 clk = ~clk;
  typedef struct packed {
    logic v; logic [HW-1:0] x; logic [VW-1:0] y; logic [5:0] rgb;
    logic [HW-1:0] ll; logic [VW-1:0] fl; logic [15:0] fc; logic fd; logic [15:0] crc;
  } snap_t;
  snap_t m, e1, e2, d;
  int k, ln, total = 0, bad = 0, vcount = 0, fdcount = 0;
  bit ph, pv, hseen, vseen;
  logic [15:0] acc;
  function automatic int mn(input int a, input int b);
    return a < b ? a : b;
  endfunction
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? (r << 1) ^ 16'h1021 : r << 1;
    return r;
  endfunction
  function automatic snap_t dut_snap();
    return {pix_valid, pix_x, pix_y, pix_rgb, line_len, frame_lines, frame_cnt, frame_done, frame_crc};
  endfunction
  task automatic model_reset();
    m = '0; e1 = '0; e2 = '0; k = 0; ln = 0;
    ph = !POL; pv = !POL; hseen = 0; vseen = 0; acc = 16'hFFFF;
  endtask
  // entered at a negedge: check outputs owed from two inputs ago, drive the next input, model it
  task automatic step(input bit hs, input bit vs, input logic [5:0] rgb);
    bit he, ve, val;
    int nk, nl;
    d = dut_snap();
    total++;
    if (d !== e2) begin
      bad++;
      $display("FAIL stream t=%0t got=%h exp=%h", $time, d, e2);
    end
    if (pix_valid) vcount++;
    if (frame_done) fdcount++;
    e2 = e1;
    hsync = hs; vsync = vs; {red, grn, blu} = rgb;
    he = hs == POL && ph != POL;
    ve = vs == POL && pv != POL;
    m.fd = ve;
    if (ve) begin
      if (vseen) m.fl = VW'(mn(ln + 1, VMAX));
      m.fc = m.fc + 16'd1;
`ifdef PIXER_CRC_EN
      m.crc = acc;
      acc = 16'hFFFF;
`endif
    end
    if (he && hseen) m.ll = HW'(mn(k + 1, HMAX));
    nk = he ? 0 : mn(k + 1, HMAX);
    nl = ve ? 0 : he ? mn(ln + 1, VMAX) : ln;
    val = nk >= HST && nk < HST + HACT && nl >= VST && nl < VST + VACT && hs != POL && vs != POL && vseen;
    m.v = val;
    if (val) begin
      m.x = HW'(nk - HST); m.y = VW'(nl - VST); m.rgb = rgb;
`ifdef PIXER_CRC_EN
      acc = crc_byte(acc, {2'b00, rgb});
`endif
    end
    k = nk; ln = nl; hseen |= he; vseen |= ve; ph = hs; pv = vs;
    e1 = m;
    @(negedge clk);
  endtask
  task automatic line(input int hlen);
    for (int c = 0; c < hlen; c++) step(c < 4 ? POL : !POL, !POL, 6'($urandom));
  endtask
  task automatic frame(input int hlen, input int l0, input int l1, input bit rnd, input logic [5:0] col);
    for (int l = l0; l < l1; l++)
      for (int c = 0; c < hlen; c++)
        step(c < 4 ? POL : !POL, l < 2 ? POL : !POL, rnd ? 6'($urandom) : col);
  endtask
  task automatic check_zero(input string nm);
    #1;
    total++;
    if (dut_snap() !== '0) begin
      bad++;
      $display("FAIL %s got=%h exp=0", nm, dut_snap());
    end
  endtask
  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      hsync = i[0]; vsync = i[1];
      @(negedge clk);
      check_zero("reset_hold");
    end
    @(negedge clk);
    rst_n = 1;
    model_reset();
    line(40);
    total++;
    if (line_len !== 0) begin bad++; $display("FAIL first_line_len got=%0d exp=0", line_len); end
  endtask
  task automatic test_geometry();
    for (int f = 1; f <= 3; f++) begin
      vcount = 0; fdcount = 0;
      frame(40, 0, 12, 1, 6'h0);
      total += 5;
      if (frame_cnt !== 16'(f)) begin bad++; $display("FAIL geo_frame_cnt got=%0d exp=%0d", frame_cnt, f); end
      if (frame_lines !== VW'(f > 1 ? 12 : 0)) begin bad++; $display("FAIL geo_frame_lines got=%0d exp=%0d", frame_lines, f > 1 ? 12 : 0); end
      if (line_len !== 40) begin bad++; $display("FAIL geo_line_len got=%0d exp=40", line_len); end
      if (vcount != HACT * VACT) begin bad++; $display("FAIL geo_valid_count got=%0d exp=%0d", vcount, HACT * VACT); end
      if (fdcount != 1) begin bad++; $display("FAIL geo_frame_done got=%0d exp=1", fdcount); end
    end
  endtask
  task automatic test_random_frames();
    int hl;
    for (int f = 0; f < 3; f++) begin
      hl = $urandom_range(30, 50);
      frame(hl, 0, 12, 1, 6'h0);
      total++;
      if (line_len !== HW'(hl)) begin bad++; $display("FAIL rand_line_len got=%0d exp=%0d", line_len, hl); end
    end
  endtask
  task automatic test_saturation();
    line(300);
    line(40);
    total++;
    if (line_len !== HW'(HMAX)) begin bad++; $display("FAIL sat_line_len got=%0d exp=%0d", line_len, HMAX); end
  endtask
  task automatic test_mid_reset();
    frame(40, 0, 6, 1, 6'h0);
    rst_n = 0;
    model_reset();
    check_zero("mid_reset");
    @(negedge clk);
    check_zero("mid_reset_hold");
    @(negedge clk);
    rst_n = 1;
    vcount = 0;
    frame(40, 6, 12, 1, 6'h0);
    total++;
    if (vcount != 0) begin bad++; $display("FAIL post_reset_valid got=%0d exp=0", vcount); end
    frame(40, 0, 12, 1, 6'h0);
    total += 2;
    if (frame_cnt !== 16'd1) begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=1", frame_cnt); end
    if (frame_lines !== 0) begin bad++; $display("FAIL reset_frame_lines got=%0d exp=0", frame_lines); end
  endtask
  task automatic test_crc();
    logic [15:0] want;
`ifdef PIXER_CRC_EN
    want = 16'hFFFF;
    for (int i = 0; i < HACT * VACT; i++) want = crc_byte(want, 8'h3F);
`else
    want = 16'h0;
`endif
    frame(40, 0, 12, 0, 6'h3F);
    frame(40, 0, 12, 0, 6'h3F);
    total++;
    if (frame_crc !== want) begin bad++; $display("FAIL crc_first got=%h exp=%h", frame_crc, want); end
    frame(40, 0, 12, 0, 6'h3F);
    total++;
    if (frame_crc !== want) begin bad++; $display("FAIL crc_repeat got=%h exp=%h", frame_crc, want); end
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_geometry();
    test_random_frames();
    test_saturation();
    test_mid_reset();
    test_crc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
